// File: rtl/regfile_param_if.sv
// Register file access bus: read address/data, single write port, ready.
interface regfile_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 3
);
  logic [NREAD*ADDR_W-1:0] i_raddr;
  logic [NREAD*DATA_W-1:0] o_rdata;
  logic                    i_wen;
  logic [ADDR_W-1:0]       i_waddr;
  logic [DATA_W-1:0]       i_wdata;
  logic                    o_ready;

  modport master (
    output i_raddr, i_wen, i_waddr, i_wdata,
    input  o_rdata, o_ready
  );

  modport slave (
    input  i_raddr, i_wen, i_waddr, i_wdata,
    output o_rdata, o_ready
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file with NREAD asynchronous read ports, one write
// port, optional hardwired-zero r0, optional write-to-read bypass, and a
// post-reset clear sweep that zeroes every register before writes are taken.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic           clk,
  input  logic           rst,
  regfile_param_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t                  state;
  state_t                  state_nx;
  logic [ADDR_W-1:0]       clr_ptr;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic [NREAD*DATA_W-1:0] rdata;
  logic                    ready;

  // State register; reset restarts the clear sweep from INIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= state_nx;
  end

  // Next state: leave INIT on the edge that clears the last register; RUN is sticky.
  always_comb begin
    state_nx = state;
    if (state == INIT && clr_ptr == '1) state_nx = RUN;
  end

  // Output decode: writes are accepted only in RUN.
  always_comb begin
    ready = (state == RUN);
  end

  // Clear pointer walks every address once per sweep; terminal compare
  // on the all-ones value means it never wraps back into a second sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                clr_ptr <= '0;
    else if (state == INIT) clr_ptr <= clr_ptr + 1'b1;
  end

  // Storage: sweep writes zeros in INIT, user writes land in RUN. The array
  // has no reset; an edge seen while rst is high drops any write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        mem[clr_ptr] <= '0;
      end else if (bus.i_wen && !(ZERO_REG != 0 && bus.i_waddr == '0)) begin
        mem[bus.i_waddr] <= bus.i_wdata;
      end
    end
  end

  // Combinational read ports: INIT, then zero register, then bypass, then array.
  always_comb begin
    rdata = '0;
    for (int k = 0; k < NREAD; k++) begin
      if (state == INIT) begin
        rdata[k*DATA_W +: DATA_W] = '0;
      end else if (ZERO_REG != 0 && bus.i_raddr[k*ADDR_W +: ADDR_W] == '0) begin
        rdata[k*DATA_W +: DATA_W] = '0;
      end else if (BYPASS != 0 && bus.i_wen &&
                   bus.i_raddr[k*ADDR_W +: ADDR_W] == bus.i_waddr) begin
        rdata[k*DATA_W +: DATA_W] = bus.i_wdata;
      end else begin
        rdata[k*DATA_W +: DATA_W] = mem[bus.i_raddr[k*ADDR_W +: ADDR_W]];
      end
    end
  end

  assign bus.o_rdata = rdata;
  assign bus.o_ready = ready;
endmodule

// File: tb/tb_regfile_param.sv
// Testbench for regfile_param: two instances share stimulus, A with the
// default options (zero register + bypass), B with both options off.
module tb_regfile_param;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREAD  = 3;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic clk;
  logic rst;
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] ra [NREAD];
  logic [NREAD*ADDR_W-1:0] ra_p;

  logic [DATA_W-1:0] rd_a [NREAD];
  logic [DATA_W-1:0] rd_b [NREAD];

  int n_cmp;
  int n_fail;

  // Reference model: sweep progress and register contents per instance.
  int                edges;
  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];

  regfile_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD)) bus_a ();
  regfile_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD)) bus_b ();

  regfile_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD),
                  .ZERO_REG(1), .BYPASS(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  regfile_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD),
                  .ZERO_REG(0), .BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always_comb begin
    ra_p = '0;
    for (int k = 0; k < NREAD; k++) ra_p[k*ADDR_W +: ADDR_W] = ra[k];
  end

  assign bus_a.i_raddr = ra_p;
  assign bus_a.i_wen   = wen;
  assign bus_a.i_waddr = waddr;
  assign bus_a.i_wdata = wdata;
  assign bus_b.i_raddr = ra_p;
  assign bus_b.i_wen   = wen;
  assign bus_b.i_waddr = waddr;
  assign bus_b.i_wdata = wdata;

  always_comb begin
    for (int k = 0; k < NREAD; k++) begin
      rd_a[k] = bus_a.o_rdata[k*DATA_W +: DATA_W];
      rd_b[k] = bus_b.o_rdata[k*DATA_W +: DATA_W];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected read on port k of instance A (is_b=0) or B (is_b=1).
  function automatic logic [DATA_W-1:0] exp_rd(input bit is_b, input int k);
    logic [ADDR_W-1:0] a;
    a = ra[k];
    if (edges < DEPTH) return '0;
    if (!is_b && a == '0) return '0;
    if (!is_b && wen && a == waddr) return wdata;
    return is_b ? mem_b[a] : mem_a[a];
  endfunction

  // Advance one rising edge, update the model from the inputs seen at it,
  // and return 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      edges = 0;
    end else if (edges < DEPTH) begin
      edges++;
      if (edges == DEPTH) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_a[i] = '0;
          mem_b[i] = '0;
        end
      end
    end else if (wen) begin
      if (waddr != '0) mem_a[waddr] = wdata;
      mem_b[waddr] = wdata;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; edges = 0; wen = 1'b0; waddr = '0; wdata = '0;
    for (int k = 0; k < NREAD; k++) ra[k] = ADDR_W'(k + 3);
    repeat (3) tick();
    n_cmp++;
    if (bus_a.o_ready !== 1'b0 || bus_b.o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got a=%b b=%b expected 0", bus_a.o_ready, bus_b.o_ready);
    end
    for (int k = 0; k < NREAD; k++) begin
      n_cmp++;
      if (rd_a[k] !== 32'h0 || rd_b[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_rdata port%0d: got a=%h b=%h expected 0", k, rd_a[k], rd_b[k]);
      end
    end
    rst = 1'b0;
    for (int e = 1; e <= DEPTH; e++) begin
      tick();
      n_cmp++;
      if (bus_a.o_ready !== (e >= DEPTH) || bus_b.o_ready !== (e >= DEPTH)) begin
        n_fail++;
        $display("FAIL ready_edge%0d: got a=%b b=%b expected %b", e,
                 bus_a.o_ready, bus_b.o_ready, (e >= DEPTH));
      end
    end
    for (int a = 0; a < DEPTH; a++) begin
      for (int k = 0; k < NREAD; k++) ra[k] = ADDR_W'(a);
      #1;
      for (int k = 0; k < NREAD; k++) begin
        n_cmp++;
        if (rd_a[k] !== 32'h0 || rd_b[k] !== 32'h0) begin
          n_fail++;
          $display("FAIL cleared r%0d port%0d: got a=%h b=%h expected 0", a, k, rd_a[k], rd_b[k]);
        end
      end
    end
  endtask

  task automatic test_write_read();
    wen = 1'b1; waddr = 5'd5;  wdata = 32'hDEADBEEF; tick();
    wen = 1'b1; waddr = 5'd31; wdata = 32'h12345678; tick();
    wen = 1'b0;
    ra[0] = 5'd5; ra[1] = 5'd31; ra[2] = 5'd4;
    #1;
    n_cmp++;
    if (rd_a[0] !== 32'hDEADBEEF || rd_a[1] !== 32'h12345678 || rd_a[2] !== 32'h0 ||
        rd_b[0] !== 32'hDEADBEEF || rd_b[1] !== 32'h12345678 || rd_b[2] !== 32'h0) begin
      n_fail++;
      $display("FAIL three_port_read: got a={%h,%h,%h} b={%h,%h,%h} expected {deadbeef,12345678,00000000}",
               rd_a[0], rd_a[1], rd_a[2], rd_b[0], rd_b[1], rd_b[2]);
    end
  endtask

  task automatic test_zero_reg();
    wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    for (int k = 0; k < NREAD; k++) ra[k] = 5'd0;
    #1;
    n_cmp++;
    if (rd_a[0] !== 32'h0 || rd_b[0] !== exp_rd(1'b1, 0)) begin
      n_fail++;
      $display("FAIL zero_reg_during: got a=%h b=%h expected a=0 b=%h", rd_a[0], rd_b[0], exp_rd(1'b1, 0));
    end
    tick();
    wen = 1'b0;
    #1;
    for (int k = 0; k < NREAD; k++) begin
      n_cmp++;
      if (rd_a[k] !== 32'h0 || rd_b[k] !== 32'hFFFFFFFF) begin
        n_fail++;
        $display("FAIL zero_reg_after port%0d: got a=%h b=%h expected a=0 b=ffffffff", k, rd_a[k], rd_b[k]);
      end
    end
  endtask

  task automatic test_bypass();
    wen = 1'b1; waddr = 5'd7; wdata = 32'h11; tick();
    waddr = 5'd7; wdata = 32'h22;
    ra[0] = 5'd5; ra[1] = 5'd7; ra[2] = 5'd7;
    #1;
    n_cmp++;
    if (rd_a[1] !== 32'h22 || rd_b[1] !== 32'h11) begin
      n_fail++;
      $display("FAIL bypass_same_cycle: got a=%h b=%h expected a=22 b=11", rd_a[1], rd_b[1]);
    end
    n_cmp++;
    if (rd_a[2] !== rd_a[1] || rd_b[2] !== rd_b[1]) begin
      n_fail++;
      $display("FAIL same_addr_ports: got a=%h/%h b=%h/%h expected equal pairs",
               rd_a[1], rd_a[2], rd_b[1], rd_b[2]);
    end
    tick();
    wen = 1'b0;
    #1;
    n_cmp++;
    if (rd_a[1] !== 32'h22 || rd_b[1] !== 32'h22) begin
      n_fail++;
      $display("FAIL bypass_after_edge: got a=%h b=%h expected 22", rd_a[1], rd_b[1]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      wen   = 1'($urandom_range(0, 1));
      waddr = ADDR_W'($urandom_range(0, DEPTH - 1));
      wdata = DATA_W'($urandom);
      for (int k = 0; k < NREAD; k++)
        ra[k] = ($urandom_range(0, 3) == 0) ? waddr : ADDR_W'($urandom_range(0, DEPTH - 1));
      #1;
      for (int k = 0; k < NREAD; k++) begin
        n_cmp++;
        if (rd_a[k] !== exp_rd(1'b0, k) || rd_b[k] !== exp_rd(1'b1, k)) begin
          n_fail++;
          $display("FAIL random c%0d port%0d r%0d: got a=%h b=%h expected a=%h b=%h", c, k, ra[k],
                   rd_a[k], rd_b[k], exp_rd(1'b0, k), exp_rd(1'b1, k));
        end
      end
      tick();
    end
    wen = 1'b0;
  endtask

  task automatic test_init_drop();
    rst = 1'b1; edges = 0; #2; rst = 1'b0;
    wen = 1'b1; waddr = 5'd3; wdata = 32'hAA;
    for (int k = 0; k < NREAD; k++) ra[k] = 5'd3;
    for (int e = 1; e < DEPTH; e++) tick();
    n_cmp++;
    if (bus_a.o_ready !== 1'b0 || bus_b.o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL init_ready_edge31: got a=%b b=%b expected 0", bus_a.o_ready, bus_b.o_ready);
    end
    wen = 1'b0;
    tick();
    n_cmp++;
    if (bus_a.o_ready !== 1'b1 || bus_b.o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL init_ready_edge32: got a=%b b=%b expected 1", bus_a.o_ready, bus_b.o_ready);
    end
    n_cmp++;
    if (rd_a[0] !== 32'h0 || rd_b[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL init_write_dropped: got a=%h b=%h expected 0", rd_a[0], rd_b[0]);
    end
  endtask

  task automatic test_reset_mid();
    wen = 1'b1; waddr = 5'd9; wdata = 32'h55; tick();
    wen = 1'b0;
    for (int k = 0; k < NREAD; k++) ra[k] = 5'd9;
    #1;
    n_cmp++;
    if (rd_a[0] !== 32'h55 || rd_b[0] !== 32'h55) begin
      n_fail++;
      $display("FAIL load_r9: got a=%h b=%h expected 55", rd_a[0], rd_b[0]);
    end
    rst = 1'b1; edges = 0;
    #1;
    n_cmp++;
    if (bus_a.o_ready !== 1'b0 || bus_b.o_ready !== 1'b0 || rd_a[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL async_ready_fall: got a=%b b=%b rd=%h expected 0", bus_a.o_ready, bus_b.o_ready, rd_a[0]);
    end
    tick();
    rst = 1'b0;
    repeat (10) tick();
    rst = 1'b1; edges = 0;
    tick();
    rst = 1'b0;
    for (int e = 1; e <= DEPTH; e++) begin
      tick();
      n_cmp++;
      if (bus_a.o_ready !== (e >= DEPTH) || bus_b.o_ready !== (e >= DEPTH)) begin
        n_fail++;
        $display("FAIL restart_ready_edge%0d: got a=%b b=%b expected %b", e,
                 bus_a.o_ready, bus_b.o_ready, (e >= DEPTH));
      end
    end
    n_cmp++;
    if (rd_a[0] !== 32'h0 || rd_b[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL r9_cleared: got a=%h b=%h expected 0", rd_a[0], rd_b[0]);
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b1; edges = 0;
    wen = 1'b0; waddr = '0; wdata = '0;
    for (int k = 0; k < NREAD; k++) ra[k] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_random();
    test_init_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
